ofswitch_stats_poller: RTL and testbench

Synthesizable AXI4-Lite read master that periodically sweeps the switch's flow statistics port: packet count, byte count, last-match time and current time. It sits directly on the nf10_upb_ofswitch s_axi_stats read channel. It presents the four words as an atomic snapshot to debug/host logic and replaces hand-written polling state machines in benches.

---
 rtl/ofswitch_stats_pkg.sv | 25 ++
 rtl/stats_axil_read_ch.sv | 58 +++++
 rtl/ofswitch_stats_poller.sv | 182 ++++++++++++++++++
 tb/tb_ofswitch_stats_poller.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofswitch_stats_pkg.sv
// rtl/ofswitch_stats_pkg.sv - shared types and default addresses for the flow statistics poller
package ofswitch_stats_pkg;

   typedef enum logic [3:0] {
      IDLE,
      AR_PKT,
      R_PKT,
      AR_BYTE,
      R_BYTE,
      AR_TIME,
      R_TIME,
      AR_CTIME,
      R_CTIME,
      COMMIT
   } t_poll_state;

   localparam logic [31:0] DEF_BASE_ADDR = 32'hC000_0000;
   localparam logic [31:0] DEF_OFF_PKT   = 32'h0000_0020;
   localparam logic [31:0] DEF_OFF_BYTE  = 32'h0000_0024;
   localparam logic [31:0] DEF_OFF_TIME  = 32'h0000_0028;
   localparam logic [31:0] DEF_OFF_CTIME = 32'h0001_0010;

   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/stats_axil_read_ch.sv
// rtl/stats_axil_read_ch.sv - single AXI4-Lite read (AR then R) with a per-phase handshake timeout
module stats_axil_read_ch #(
   parameter int C_TIMEOUT = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic [31:0] req_addr,
   output logic [31:0] araddr,
   output logic        arvalid,
   input  logic        arready,
   input  logic        rvalid,
   output logic        rready,
   output logic        ar_done,
   output logic        r_done,
   output logic        timeout
);

   localparam int TW = $clog2(C_TIMEOUT + 1);

   logic [TW-1:0] wait_cnt;

   assign ar_done = arvalid & arready;
   assign r_done  = rready & rvalid;
   // A handshake landing on the final allowed cycle still completes normally.
   assign timeout = (arvalid | rready) & ~ar_done & ~r_done & (wait_cnt == TW'(C_TIMEOUT - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         araddr   <= '0;
         arvalid  <= 1'b0;
         rready   <= 1'b0;
         wait_cnt <= '0;
      end else if (timeout) begin
         arvalid  <= 1'b0;
         rready   <= 1'b0;
         wait_cnt <= '0;
      end else begin
         if (req) begin
            arvalid <= 1'b1;
            araddr  <= req_addr;
         end else if (ar_done) begin
            arvalid <= 1'b0;
         end

         if (ar_done)
            rready <= 1'b1;
         else if (r_done)
            rready <= 1'b0;

         if (req || ar_done || r_done)
            wait_cnt <= '0;
         else if (arvalid || rready)
            wait_cnt <= wait_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/ofswitch_stats_poller.sv
// rtl/ofswitch_stats_poller.sv - periodic AXI4-Lite sweep of flow statistics into an atomic snapshot
module ofswitch_stats_poller
   import ofswitch_stats_pkg::*;
#(
   parameter logic [31:0] C_BASE_ADDR     = DEF_BASE_ADDR,
   parameter logic [31:0] C_OFF_PKT       = DEF_OFF_PKT,
   parameter logic [31:0] C_OFF_BYTE      = DEF_OFF_BYTE,
   parameter logic [31:0] C_OFF_TIME      = DEF_OFF_TIME,
   parameter logic [31:0] C_OFF_CTIME     = DEF_OFF_CTIME,
   parameter int          C_POLL_INTERVAL = 4096,
   parameter int          C_TIMEOUT       = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        clear_err,
   output logic [31:0] m_axi_stats_araddr,
   output logic [2:0]  m_axi_stats_arprot,
   output logic        m_axi_stats_arvalid,
   input  logic        m_axi_stats_arready,
   input  logic        m_axi_stats_rvalid,
   output logic        m_axi_stats_rready,
   input  logic [31:0] m_axi_stats_rdata,
   input  logic [1:0]  m_axi_stats_rresp,
   output logic [31:0] stat_pkt_count,
   output logic [31:0] stat_byte_count,
   output logic [31:0] stat_time,
   output logic [31:0] stat_ctime,
   output logic        snapshot_valid,
   output logic [15:0] snapshot_seq,
   output logic        busy,
   output logic        resp_err,
   output logic        timeout_err
);

   localparam int IW = (C_POLL_INTERVAL > 1) ? $clog2(C_POLL_INTERVAL) : 1;

   t_poll_state state, next_state;

   logic [IW-1:0] ival_cnt;
   logic          auto_wrap;
   logic          pending;
   logic          sweep_bad;
   logic          rd_req;
   logic [31:0]   rd_addr;
   logic          ar_done, r_done, rd_timeout;
   logic          r_bad;
   logic [31:0]   sh_pkt, sh_byte, sh_time, sh_ctime;

   assign m_axi_stats_arprot = 3'b000;
   assign auto_wrap = (C_POLL_INTERVAL != 0) && (ival_cnt == IW'(C_POLL_INTERVAL - 1));
   assign r_bad     = r_done && (m_axi_stats_rresp != AXI_RESP_OKAY);

   stats_axil_read_ch #(
      .C_TIMEOUT (C_TIMEOUT)
   ) u_read_ch (
      .clk      (clk),
      .reset    (reset),
      .req      (rd_req),
      .req_addr (rd_addr),
      .araddr   (m_axi_stats_araddr),
      .arvalid  (m_axi_stats_arvalid),
      .arready  (m_axi_stats_arready),
      .rvalid   (m_axi_stats_rvalid),
      .rready   (m_axi_stats_rready),
      .ar_done  (ar_done),
      .r_done   (r_done),
      .timeout  (rd_timeout)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:     if (pending) next_state = AR_PKT;
         AR_PKT:   if (rd_timeout) next_state = IDLE; else if (ar_done) next_state = R_PKT;
         R_PKT:    if (rd_timeout) next_state = IDLE; else if (r_done)  next_state = AR_BYTE;
         AR_BYTE:  if (rd_timeout) next_state = IDLE; else if (ar_done) next_state = R_BYTE;
         R_BYTE:   if (rd_timeout) next_state = IDLE; else if (r_done)  next_state = AR_TIME;
         AR_TIME:  if (rd_timeout) next_state = IDLE; else if (ar_done) next_state = R_TIME;
         R_TIME:   if (rd_timeout) next_state = IDLE; else if (r_done)  next_state = AR_CTIME;
         AR_CTIME: if (rd_timeout) next_state = IDLE; else if (ar_done) next_state = R_CTIME;
         R_CTIME:  if (rd_timeout) next_state = IDLE; else if (r_done)  next_state = COMMIT;
         COMMIT:   next_state = IDLE;
         default:  next_state = IDLE;
      endcase
   end

   // A read is launched on every entry into an AR state; the channel registers it.
   always_comb begin
      busy    = (state != IDLE);
      rd_req  = 1'b0;
      rd_addr = '0;
      if (next_state != state) begin
         case (next_state)
            AR_PKT:   begin rd_req = 1'b1; rd_addr = C_BASE_ADDR + C_OFF_PKT;   end
            AR_BYTE:  begin rd_req = 1'b1; rd_addr = C_BASE_ADDR + C_OFF_BYTE;  end
            AR_TIME:  begin rd_req = 1'b1; rd_addr = C_BASE_ADDR + C_OFF_TIME;  end
            AR_CTIME: begin rd_req = 1'b1; rd_addr = C_BASE_ADDR + C_OFF_CTIME; end
            default:  begin rd_req = 1'b0; rd_addr = '0; end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ival_cnt        <= '0;
         pending         <= 1'b0;
         sweep_bad       <= 1'b0;
         sh_pkt          <= '0;
         sh_byte         <= '0;
         sh_time         <= '0;
         sh_ctime        <= '0;
         stat_pkt_count  <= '0;
         stat_byte_count <= '0;
         stat_time       <= '0;
         stat_ctime      <= '0;
         snapshot_valid  <= 1'b0;
         snapshot_seq    <= '0;
         resp_err        <= 1'b0;
         timeout_err     <= 1'b0;
      end else begin
         if (auto_wrap || C_POLL_INTERVAL == 0)
            ival_cnt <= '0;
         else
            ival_cnt <= ival_cnt + 1'b1;

         // New triggers win over the clear so a request arriving on the launch cycle is kept.
         if (auto_wrap || start)
            pending <= 1'b1;
         else if (state == IDLE && next_state == AR_PKT)
            pending <= 1'b0;

         if (state == IDLE)
            sweep_bad <= 1'b0;
         else if (r_bad)
            sweep_bad <= 1'b1;

         if (rd_timeout) begin
            sh_pkt   <= '0;
            sh_byte  <= '0;
            sh_time  <= '0;
            sh_ctime <= '0;
         end else if (r_done) begin
            case (state)
               R_PKT:   sh_pkt   <= m_axi_stats_rdata;
               R_BYTE:  sh_byte  <= m_axi_stats_rdata;
               R_TIME:  sh_time  <= m_axi_stats_rdata;
               R_CTIME: sh_ctime <= m_axi_stats_rdata;
               default: ;
            endcase
         end

         snapshot_valid <= 1'b0;
         if (state == COMMIT && !sweep_bad) begin
            stat_pkt_count  <= sh_pkt;
            stat_byte_count <= sh_byte;
            stat_time       <= sh_time;
            stat_ctime      <= sh_ctime;
            snapshot_valid  <= 1'b1;
            snapshot_seq    <= snapshot_seq + 16'd1;
         end

         if (r_bad)
            resp_err <= 1'b1;
         else if (clear_err)
            resp_err <= 1'b0;

         if (rd_timeout)
            timeout_err <= 1'b1;
         else if (clear_err)
            timeout_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ofswitch_stats_poller.sv
// tb/tb_ofswitch_stats_poller.sv - scoreboard bench for the flow statistics poller
module tb_ofswitch_stats_poller;

   localparam logic [31:0] A_PKT   = 32'hC000_0020;
   localparam logic [31:0] A_BYTE  = 32'hC000_0024;
   localparam logic [31:0] A_TIME  = 32'hC000_0028;
   localparam logic [31:0] A_CTIME = 32'hC001_0010;

   logic        clk = 1'b0;
   logic        reset, start, clear_err;
   logic [31:0] araddr;
   logic [2:0]  arprot;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic [31:0] stat_pkt_count, stat_byte_count, stat_time, stat_ctime;
   logic        snapshot_valid, busy, resp_err, timeout_err;
   logic [15:0] snapshot_seq;

   logic [31:0] araddr2, pkt2, byte2, time2, ctime2;
   logic [2:0]  arprot2;
   logic        arvalid2, rready2, sv2, busy2, rerr2, terr2;
   logic [15:0] seq2;

   typedef struct {
      logic [31:0] p, b, t, c;
      logic [15:0] s;
   } exp_t;
   exp_t exp_q[$];

   int n_tests = 0, n_fail = 0;
   int busy_cycles = 0, snap_pulses = 0, cyc = 0, p2_last = 0, p2_interval = 0;
   logic [15:0] exp_seq = 16'd0;

   always #5 clk = ~clk;

   ofswitch_stats_poller #(
      .C_POLL_INTERVAL (0),
      .C_TIMEOUT       (256)
   ) dut (
      .clk                 (clk),
      .reset               (reset),
      .start               (start),
      .clear_err           (clear_err),
      .m_axi_stats_araddr  (araddr),
      .m_axi_stats_arprot  (arprot),
      .m_axi_stats_arvalid (arvalid),
      .m_axi_stats_arready (arready),
      .m_axi_stats_rvalid  (rvalid),
      .m_axi_stats_rready  (rready),
      .m_axi_stats_rdata   (rdata),
      .m_axi_stats_rresp   (rresp),
      .stat_pkt_count      (stat_pkt_count),
      .stat_byte_count     (stat_byte_count),
      .stat_time           (stat_time),
      .stat_ctime          (stat_ctime),
      .snapshot_valid      (snapshot_valid),
      .snapshot_seq        (snapshot_seq),
      .busy                (busy),
      .resp_err            (resp_err),
      .timeout_err         (timeout_err)
   );

   // Auto-polling instance against an always-ready slave that echoes the address as data.
   ofswitch_stats_poller #(
      .C_POLL_INTERVAL (16),
      .C_TIMEOUT       (256)
   ) dut_auto (
      .clk                 (clk),
      .reset               (reset),
      .start               (1'b0),
      .clear_err           (1'b0),
      .m_axi_stats_araddr  (araddr2),
      .m_axi_stats_arprot  (arprot2),
      .m_axi_stats_arvalid (arvalid2),
      .m_axi_stats_arready (1'b1),
      .m_axi_stats_rvalid  (1'b1),
      .m_axi_stats_rready  (rready2),
      .m_axi_stats_rdata   (araddr2),
      .m_axi_stats_rresp   (2'b00),
      .stat_pkt_count      (pkt2),
      .stat_byte_count     (byte2),
      .stat_time           (time2),
      .stat_ctime          (ctime2),
      .snapshot_valid      (sv2),
      .snapshot_seq        (seq2),
      .busy                (busy2),
      .resp_err            (rerr2),
      .timeout_err         (terr2)
   );

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (busy) busy_cycles <= busy_cycles + 1;
      if (snapshot_valid) snap_pulses <= snap_pulses + 1;
      if (sv2) begin
         p2_interval <= cyc - p2_last;
         p2_last     <= cyc;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic pulse_clear();
      clear_err = 1'b1;
      @(negedge clk);
      clear_err = 1'b0;
   endtask

   task automatic serve_read(input logic [31:0] addr, input int ar_delay, input logic [31:0] data,
                             input logic [1:0] resp, input logic clr);
      int  n;
      logic stable;
      n = 0;
      while (!arvalid && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!arvalid) begin
         check("arvalid_wait", 32'(arvalid), 32'd1);
         return;
      end
      check("araddr", araddr, addr);
      stable = 1'b1;
      repeat (ar_delay) begin
         @(negedge clk);
         if (!arvalid || araddr !== addr) stable = 1'b0;
      end
      if (ar_delay > 0) check("ar_hold", 32'(stable), 32'd1);
      arready = 1'b1;
      @(negedge clk);
      arready = 1'b0;
      check("rready", 32'(rready), 32'd1);
      rvalid    = 1'b1;
      rdata     = data;
      rresp     = resp;
      clear_err = clr;
      @(negedge clk);
      rvalid    = 1'b0;
      rresp     = 2'b00;
      clear_err = 1'b0;
   endtask

   task automatic wait_commit();
      exp_t e;
      int   n;
      n = 0;
      while (!snapshot_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!snapshot_valid || exp_q.size() == 0) begin
         check("commit_seen", 32'(snapshot_valid), 32'd1);
         return;
      end
      e = exp_q.pop_front();
      check("stat_pkt", stat_pkt_count, e.p);
      check("stat_byte", stat_byte_count, e.b);
      check("stat_time", stat_time, e.t);
      check("stat_ctime", stat_ctime, e.c);
      check("snap_seq", 32'(snapshot_seq), 32'(e.s));
      @(negedge clk);
      check("snap_pulse_width", 32'(snapshot_valid), 32'd0);
   endtask

   task automatic push_exp(input logic [31:0] p, b, t, c);
      exp_seq++;
      exp_q.push_back('{p: p, b: b, t: t, c: c, s: exp_seq});
   endtask

   task automatic sweep(input logic [31:0] p, b, t, c, input int byte_delay,
                        input logic [1:0] time_resp, input logic clr_on_time);
      int p0;
      if (time_resp == 2'b00) push_exp(p, b, t, c);
      serve_read(A_PKT, 0, p, 2'b00, 1'b0);
      serve_read(A_BYTE, byte_delay, b, 2'b00, 1'b0);
      serve_read(A_TIME, 0, t, time_resp, clr_on_time);
      serve_read(A_CTIME, 0, c, 2'b00, 1'b0);
      if (time_resp == 2'b00) begin
         wait_commit();
      end else begin
         p0 = snap_pulses;
         repeat (4) @(negedge clk);
         check("no_snapshot_on_bad", 32'(snap_pulses - p0), 32'd0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int b0, p0, n;
      logic seen;
      reset = 1'b1; start = 1'b0; clear_err = 1'b0;
      arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
      repeat (3) @(negedge clk);
      check("reset_outputs", 32'(|{araddr, arvalid, rready, busy, snapshot_valid, snapshot_seq,
                                    stat_pkt_count, stat_byte_count, stat_time, stat_ctime,
                                    resp_err, timeout_err}), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Basic sweep with an immediate slave
      b0 = busy_cycles;
      pulse_start();
      sweep(32'd5, 32'd320, 32'd77, 32'd1000, 0, 2'b00, 1'b0);
      check("busy_cycles", 32'(busy_cycles - b0), 32'd9);
      check("arprot", 32'(arprot), 32'd0);

      // Address stall on the byte read
      pulse_start();
      sweep(32'd11, 32'd22, 32'd33, 32'd44, 10, 2'b00, 1'b0);

      // Error response on the time read
      pulse_start();
      sweep(32'd1, 32'd2, 32'd3, 32'd4, 0, 2'b10, 1'b0);
      check("resp_err_set", 32'(resp_err), 32'd1);
      check("stat_pkt_kept", stat_pkt_count, 32'd11);
      check("stat_ctime_kept", stat_ctime, 32'd44);
      pulse_clear();
      check("resp_err_cleared", 32'(resp_err), 32'd0);

      // Clear coinciding with a new error: the set wins
      pulse_start();
      sweep(32'd9, 32'd9, 32'd9, 32'd9, 0, 2'b11, 1'b1);
      check("resp_err_set_wins", 32'(resp_err), 32'd1);
      pulse_clear();

      // Address never accepted
      pulse_start();
      n = 0;
      while (!arvalid && n < 10) begin @(negedge clk); n++; end
      n = 0;
      while (!timeout_err && n < 400) begin @(negedge clk); n++; end
      check("timeout_cycles", 32'(n), 32'd256);
      check("timeout_idle", 32'(busy), 32'd0);
      check("timeout_arvalid", 32'(arvalid), 32'd0);
      check("timeout_stat_kept", stat_pkt_count, 32'd11);
      pulse_clear();
      check("timeout_err_cleared", 32'(timeout_err), 32'd0);
      pulse_start();
      sweep(32'd6, 32'd7, 32'd8, 32'd9, 0, 2'b00, 1'b0);

      // Three starts around one sweep coalesce into exactly one more sweep
      p0 = snap_pulses;
      pulse_start();
      push_exp(32'hA1, 32'hA2, 32'hA3, 32'hA4);
      serve_read(A_PKT, 0, 32'hA1, 2'b00, 1'b0);
      pulse_start();
      serve_read(A_BYTE, 0, 32'hA2, 2'b00, 1'b0);
      pulse_start();
      serve_read(A_TIME, 0, 32'hA3, 2'b00, 1'b0);
      serve_read(A_CTIME, 0, 32'hA4, 2'b00, 1'b0);
      wait_commit();
      sweep(32'hB1, 32'hB2, 32'hB3, 32'hB4, 0, 2'b00, 1'b0);
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (arvalid || busy) seen = 1'b1;
      end
      check("no_third_sweep", 32'(seen), 32'd0);
      check("coalesced_sweeps", 32'(snap_pulses - p0), 32'd2);

      // Reset while the byte read is in its data phase
      pulse_start();
      serve_read(A_PKT, 0, 32'h55, 2'b00, 1'b0);
      n = 0;
      while (!arvalid && n < 10) begin @(negedge clk); n++; end
      arready = 1'b1;
      @(negedge clk);
      arready = 1'b0;
      check("in_r_byte", 32'(rready), 32'd1);
      reset = 1'b1;
      #1;
      check("midsweep_reset_outputs", 32'(|{araddr, arvalid, rready, busy, snapshot_valid, snapshot_seq,
                                             stat_pkt_count, stat_byte_count, stat_time, stat_ctime,
                                             resp_err, timeout_err}), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      exp_seq = 16'd0;
      exp_q.delete();
      @(negedge clk);
      pulse_start();
      sweep(32'd100, 32'd200, 32'd300, 32'd400, 0, 2'b00, 1'b0);

      // Auto-polling instance: one sweep per interval wrap
      repeat (80) @(negedge clk);
      check("auto_interval", 32'(p2_interval), 32'd16);
      check("auto_pkt", pkt2, A_PKT);
      check("auto_ctime", ctime2, A_CTIME);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
